// File: rtl/dense_layer_ctrl.sv
// ---------------------------------------------------------------------------
// dense_layer_ctrl
//
// Sequencer for the fully-connected stage. A start request walks every
// neuron over the input/weight/bias ROMs (all with one cycle of read
// latency), accumulates signed Q-format products, adds the bias, rescales
// by FRAC, saturates to DATA_W, optionally applies ReLU and writes one
// result per neuron to the output buffer. At the end of a run it pulses
// done_out and presents the last neuron's result and the argmax index.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   start      run request, only looked at while idle
//   in_addr    input ROM address            (in_data one cycle later)
//   w_addr     weight ROM address           (neuron*N_IN + i)
//   b_addr     bias ROM address             (current neuron)
//   out_we     output buffer write strobe
//   out_addr   output buffer address
//   out_data   neuron result, signed, FRAC fractional bits
//   busy       high whenever not idle
//   done_out   one-cycle pulse when a run completes
//   final_out  result of the last neuron, held until the next done_out
//   class_idx  index of the largest result, held until the next done_out
// ---------------------------------------------------------------------------
module dense_layer_ctrl #(
    parameter int N_IN   = 16,
    parameter int N_OUT  = 10,
    parameter int DATA_W = 16,
    parameter int FRAC   = 8,
    parameter int ACC_W  = 40,
    parameter int RELU   = 1,
    localparam int IN_AW  = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int WA_W   = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    localparam int OUT_AW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic [IN_AW-1:0]    in_addr,
    input  logic [DATA_W-1:0]   in_data,
    output logic [WA_W-1:0]     w_addr,
    input  logic [DATA_W-1:0]   w_data,
    output logic [OUT_AW-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_data,
    output logic                out_we,
    output logic [OUT_AW-1:0]   out_addr,
    output logic [DATA_W-1:0]   out_data,
    output logic                busy,
    output logic                done_out,
    output logic [DATA_W-1:0]   final_out,
    output logic [OUT_AW-1:0]   class_idx
);

    // Step counter inside a neuron: 0..N_IN (N_IN+1 MAC cycles).
    localparam int K_W = $clog2(N_IN + 1);

    // Saturation bounds expressed at the width of the rescaled sum.
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN =
        {{(ACC_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_BIAS,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                    state_reg;
    state_t                    state_next;

    logic [K_W-1:0]            k_reg;
    logic [OUT_AW-1:0]         neuron_reg;
    logic [WA_W-1:0]           w_base_reg;      // neuron_reg * N_IN, kept incrementally
    logic signed [ACC_W-1:0]   acc_reg;
    logic signed [DATA_W-1:0]  out_data_reg;
    logic [OUT_AW-1:0]         out_addr_reg;
    logic signed [DATA_W-1:0]  best_reg;
    logic [OUT_AW-1:0]         best_idx_reg;
    logic                      done_out_reg;
    logic [DATA_W-1:0]         final_out_reg;
    logic [OUT_AW-1:0]         class_idx_reg;

    logic                      last_neuron;
    logic                      k_at_end;
    logic [IN_AW-1:0]          k_lo;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W:0]      acc_ext;
    logic signed [ACC_W:0]      bias_ext;
    logic signed [ACC_W:0]      sum_full;
    logic signed [ACC_W:0]      shifted;
    logic signed [DATA_W-1:0]   sat_val;
    logic signed [DATA_W-1:0]   result;

    assign last_neuron = (neuron_reg == OUT_AW'(N_OUT - 1));
    assign k_at_end    = (k_reg == K_W'(N_IN));
    assign k_lo        = k_reg[IN_AW-1:0];

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        busy       = 1'b1;
        out_we     = 1'b0;
        in_addr    = '0;
        w_addr     = '0;

        case (state_reg)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = S_MAC;
                end
            end
            S_MAC: begin
                // The final MAC cycle only consumes data; no new address.
                if (!k_at_end) begin
                    in_addr = k_lo;
                    w_addr  = w_base_reg + WA_W'(k_lo);
                end
                if (k_at_end) begin
                    state_next = S_BIAS;
                end
            end
            S_BIAS: begin
                state_next = S_WRITE;
            end
            S_WRITE: begin
                out_we     = 1'b1;
                state_next = last_neuron ? S_DONE : S_MAC;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Bias address is steady for the whole neuron so b_data is ready in BIAS.
    assign b_addr = neuron_reg;

    // ---------------------------------------------------------------------
    // Arithmetic: product, bias add, rescale, saturate, optional ReLU
    // ---------------------------------------------------------------------
    assign prod     = $signed(in_data) * $signed(w_data);
    assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign acc_ext  = {acc_reg[ACC_W-1], acc_reg};
    assign bias_ext = {{(ACC_W + 1 - DATA_W){b_data[DATA_W-1]}}, b_data};
    assign sum_full = acc_ext + (bias_ext <<< FRAC);
    // Arithmetic right shift truncates toward minus infinity.
    assign shifted  = sum_full >>> FRAC;

    always_comb begin
        if (shifted > SAT_MAX) begin
            sat_val = {1'b0, {(DATA_W - 1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            sat_val = {1'b1, {(DATA_W - 1){1'b0}}};
        end else begin
            sat_val = shifted[DATA_W-1:0];
        end
    end

    generate
        if (RELU != 0) begin : g_relu
            assign result = sat_val[DATA_W-1] ? '0 : sat_val;
        end else begin : g_linear
            assign result = sat_val;
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            k_reg         <= '0;
            neuron_reg    <= '0;
            w_base_reg    <= '0;
            acc_reg       <= '0;
            out_data_reg  <= '0;
            out_addr_reg  <= '0;
            best_reg      <= '0;
            best_idx_reg  <= '0;
            done_out_reg  <= 1'b0;
            final_out_reg <= '0;
            class_idx_reg <= '0;
        end else begin
            done_out_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        k_reg      <= '0;
                        neuron_reg <= '0;
                        w_base_reg <= '0;
                        acc_reg    <= '0;
                    end
                end
                S_MAC: begin
                    // Cycle 0 only issues addresses; data arrives from cycle 1.
                    if (k_reg != '0) begin
                        acc_reg <= acc_reg + prod_ext;
                    end
                    if (!k_at_end) begin
                        k_reg <= k_reg + K_W'(1);
                    end
                end
                S_BIAS: begin
                    out_data_reg <= result;
                    out_addr_reg <= neuron_reg;
                end
                S_WRITE: begin
                    // Strict compare keeps the lower index on ties.
                    if (neuron_reg == '0 || out_data_reg > best_reg) begin
                        best_reg     <= out_data_reg;
                        best_idx_reg <= neuron_reg;
                    end
                    acc_reg <= '0;
                    k_reg   <= '0;
                    if (!last_neuron) begin
                        neuron_reg <= neuron_reg + OUT_AW'(1);
                        w_base_reg <= w_base_reg + WA_W'(N_IN);
                    end
                end
                S_DONE: begin
                    done_out_reg  <= 1'b1;
                    final_out_reg <= out_data_reg;
                    class_idx_reg <= best_idx_reg;
                    neuron_reg    <= '0;
                    w_base_reg    <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign out_addr  = out_addr_reg;
    assign out_data  = out_data_reg;
    assign done_out  = done_out_reg;
    assign final_out = final_out_reg;
    assign class_idx = class_idx_reg;

endmodule

// File: tb/tb_dense_layer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dense_layer_ctrl
//
// Directed bench for dense_layer_ctrl with N_IN=4, N_OUT=2. Two instances
// share stimulus and ROM contents: u_relu (RELU=1) and u_lin (RELU=0).
// Each ROM port is modelled as a registered read of a shared array.
// ---------------------------------------------------------------------------
module tb_dense_layer_ctrl;

    localparam int N_IN   = 4;
    localparam int N_OUT  = 2;
    localparam int DATA_W = 16;

    logic        clk;
    logic        reset;
    logic        start;

    // ROM contents
    logic [15:0] in_mem [N_IN];
    logic [15:0] w_mem  [N_IN*N_OUT];
    logic [15:0] b_mem  [N_OUT];

    // RELU=1 instance
    logic [1:0]  in_addr1;
    logic [2:0]  w_addr1;
    logic [0:0]  b_addr1;
    logic [15:0] in_q1, w_q1, b_q1;
    logic        out_we1, busy1, done1;
    logic [0:0]  out_addr1, class1;
    logic [15:0] out_data1, final1;

    // RELU=0 instance
    logic [1:0]  in_addr0;
    logic [2:0]  w_addr0;
    logic [0:0]  b_addr0;
    logic [15:0] in_q0, w_q0, b_q0;
    logic        out_we0, busy0, done0;
    logic [0:0]  out_addr0, class0;
    logic [15:0] out_data0, final0;

    dense_layer_ctrl #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .FRAC(8), .ACC_W(40), .RELU(1)
    ) u_relu (
        .clk(clk), .reset(reset), .start(start),
        .in_addr(in_addr1), .in_data(in_q1),
        .w_addr(w_addr1), .w_data(w_q1),
        .b_addr(b_addr1), .b_data(b_q1),
        .out_we(out_we1), .out_addr(out_addr1), .out_data(out_data1),
        .busy(busy1), .done_out(done1), .final_out(final1), .class_idx(class1)
    );

    dense_layer_ctrl #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .FRAC(8), .ACC_W(40), .RELU(0)
    ) u_lin (
        .clk(clk), .reset(reset), .start(start),
        .in_addr(in_addr0), .in_data(in_q0),
        .w_addr(w_addr0), .w_data(w_q0),
        .b_addr(b_addr0), .b_data(b_q0),
        .out_we(out_we0), .out_addr(out_addr0), .out_data(out_data0),
        .busy(busy0), .done_out(done0), .final_out(final0), .class_idx(class0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        in_q1 <= in_mem[in_addr1];
        w_q1  <= w_mem[w_addr1];
        b_q1  <= b_mem[b_addr1];
        in_q0 <= in_mem[in_addr0];
        w_q0  <= w_mem[w_addr0];
        b_q0  <= b_mem[b_addr0];
    end

    int vectors;
    int miscompares;

    // Results of the most recent run
    int wd1 [4];
    int wa1 [4];
    int wd0 [4];
    int wa0 [4];
    int nw1, nw0;
    int lat1, lat0;
    int busy_n;
    int extra_done;
    int extra_busy;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_uniform(input logic [15:0] iv, input logic [15:0] wv,
                                input logic [15:0] b0, input logic [15:0] b1);
        for (int i = 0; i < N_IN; i++) in_mem[i] = iv;
        for (int i = 0; i < N_IN*N_OUT; i++) w_mem[i] = wv;
        b_mem[0] = b0;
        b_mem[1] = b1;
    endtask

    // Issue one start pulse, then observe at every falling edge until
    // done_out (bounded). Optionally re-pulses start at cycle pulse_at.
    // Afterwards watches 10 more cycles for stray done/busy activity.
    task automatic run_dut(input int pulse_at);
        nw1 = 0; nw0 = 0; lat1 = -1; lat0 = -1; busy_n = 0;
        extra_done = 0; extra_busy = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (c == pulse_at)     start = 1'b1;
            if (c == pulse_at + 1) start = 1'b0;
            if (out_we1 && nw1 < 4) begin
                wd1[nw1] = int'($signed(out_data1));
                wa1[nw1] = int'(out_addr1);
                nw1++;
            end
            if (out_we0 && nw0 < 4) begin
                wd0[nw0] = int'($signed(out_data0));
                wa0[nw0] = int'(out_addr0);
                nw0++;
            end
            if (busy1) busy_n++;
            if (done0 && lat0 < 0) lat0 = c;
            if (done1) begin
                lat1 = c;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done1) extra_done++;
            if (busy1) extra_busy++;
        end
    endtask

    task automatic check_run(input string tn, input int e1_0, input int e1_1,
                             input int e0_0, input int e0_1, input int ecls1,
                             input int ecls0);
        chk({tn, " lat"}, lat1, 15);
        chk({tn, " lat_lin"}, lat0, 15);
        chk({tn, " busy_cycles"}, busy_n, 15);
        chk({tn, " writes"}, nw1, 2);
        chk({tn, " writes_lin"}, nw0, 2);
        chk({tn, " wr0_addr"}, wa1[0], 0);
        chk({tn, " wr1_addr"}, wa1[1], 1);
        chk({tn, " wr0_data"}, wd1[0], e1_0);
        chk({tn, " wr1_data"}, wd1[1], e1_1);
        chk({tn, " wr0_data_lin"}, wd0[0], e0_0);
        chk({tn, " wr1_data_lin"}, wd0[1], e0_1);
        chk({tn, " final"}, int'($signed(final1)), e1_1);
        chk({tn, " final_lin"}, int'($signed(final0)), e0_1);
        chk({tn, " class"}, int'(class1), ecls1);
        chk({tn, " class_lin"}, int'(class0), ecls0);
        chk({tn, " extra_done"}, extra_done, 0);
        chk({tn, " extra_busy"}, extra_busy, 0);
        $display("%s: writes=%0d,%0d final=%0d class=%0d lat=%0d", tn,
                 wd1[0], wd1[1], $signed(final1), class1, lat1);
    endtask

    int dpos [4];
    int ndone;
    int we_after_rst;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1;
        start = 1'b0;
        load_uniform(16'd0, 16'd0, 16'd0, 16'd0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy",      busy1, 0);
        chk("rst done",      done1, 0);
        chk("rst out_we",    out_we1, 0);
        chk("rst out_addr",  out_addr1, 0);
        chk("rst out_data",  out_data1, 0);
        chk("rst final",     final1, 0);
        chk("rst class",     class1, 0);
        chk("rst in_addr",   in_addr1, 0);
        chk("rst w_addr",    w_addr1, 0);
        chk("rst b_addr",    b_addr1, 0);
        $display("reset: busy=%0d done=%0d out_we=%0d", busy1, done1, out_we1);
        reset = 1'b0;

        // T1: 1.0 * 0.5 * 4 + bias 0.25 = 2.25 -> 576
        load_uniform(16'd256, 16'd128, 16'd64, 16'd64);
        run_dut(-10);
        check_run("T1", 576, 576, 576, 576, 0, 0);

        // T2: positive saturation
        load_uniform(16'h7F00, 16'h7F00, 16'd0, 16'd0);
        run_dut(-10);
        check_run("T2", 32767, 32767, 32767, 32767, 0, 0);

        // T3: negative result, ReLU clamps it
        load_uniform(16'd256, 16'hFF00, 16'd0, 16'd0);
        run_dut(-10);
        check_run("T3", 0, 0, -1024, -1024, 0, 0);

        // T4: bias only, argmax picks neuron 1
        load_uniform(16'd256, 16'd0, 16'd0, 16'd512);
        run_dut(-10);
        check_run("T4", 0, 512, 0, 512, 1, 1);

        // T7: truncation toward -inf (-1/256 -> -1) and negative saturation
        in_mem[0] = 16'd1;
        in_mem[1] = 16'h7F00;
        in_mem[2] = 16'h7F00;
        in_mem[3] = 16'h7F00;
        w_mem[0] = 16'hFFFF; w_mem[1] = 16'd0;    w_mem[2] = 16'd0;    w_mem[3] = 16'd0;
        w_mem[4] = 16'd0;    w_mem[5] = 16'h8100; w_mem[6] = 16'h8100; w_mem[7] = 16'h8100;
        b_mem[0] = 16'd0;
        b_mem[1] = 16'd0;
        run_dut(-10);
        check_run("T7", 0, 0, -1, -32768, 0, 0);

        // T5a: start pulsed mid-run is ignored
        load_uniform(16'd256, 16'd128, 16'd64, 16'd64);
        run_dut(5);
        check_run("T5a", 576, 576, 576, 576, 0, 0);

        // T5b: start held high -> done every 16 cycles
        ndone = 0;
        @(negedge clk) start = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done1) begin
                if (ndone < 4) dpos[ndone] = c;
                ndone++;
            end
        end
        start = 1'b0;
        chk("T5b done_count", ndone, 3);
        chk("T5b done0_at", dpos[0], 15);
        chk("T5b done1_at", dpos[1], 31);
        chk("T5b done2_at", dpos[2], 47);
        $display("T5b: dones=%0d at %0d,%0d,%0d", ndone, dpos[0], dpos[1], dpos[2]);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!busy1) break;
        end
        chk("T5b drained", busy1, 0);

        // T6: reset during MAC of neuron 1
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 9; c++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("T6 busy_after_rst",  busy1, 0);
        chk("T6 out_data_zero",   out_data1, 0);
        chk("T6 out_addr_zero",   out_addr1, 0);
        chk("T6 final_zero",      final1, 0);
        chk("T6 class_zero",      class1, 0);
        we_after_rst = 0;
        if (out_we1) we_after_rst++;
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_we1 || out_we0 || done1) we_after_rst++;
        end
        chk("T6 no_we_after_rst", we_after_rst, 0);
        $display("T6: busy=%0d out_data=%0d we_after=%0d", busy1, out_data1, we_after_rst);
        run_dut(-10);
        check_run("T6 rerun", 576, 576, 576, 576, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
